// File: rtl/sequential_shifter.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROR by 0..31, one bit per clock.
// The capture edge already applies the first step, so a shift by N takes max(N,1) busy cycles.
module sequential_shifter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] inp_shifter,
    input  logic [4:0]   shamt,
    input  logic [1:0]   control,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out_shifter
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    state_t       state_q, state_d;
    logic [W-1:0] data_q,  data_d;
    logic [1:0]   op_q,    op_d;
    logic [4:0]   cnt_q,   cnt_d;

    function automatic logic [W-1:0] step1(input logic [W-1:0] d, input logic [1:0] op);
        case (op)
            OP_LSL:  step1 = {d[W-2:0], 1'b0};
            OP_LSR:  step1 = {1'b0, d[W-1:1]};
            OP_ASR:  step1 = {d[W-1], d[W-1:1]};
            default: step1 = {d[0], d[W-1:1]};
        endcase
    endfunction

    // cnt holds the steps still to go after the one applied this edge
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = control;
                    if (shamt == 5'd0) begin
                        data_d  = inp_shifter;
                        cnt_d   = 5'd0;
                        state_d = DONE;
                    end else begin
                        data_d  = step1(inp_shifter, control);
                        cnt_d   = shamt - 5'd1;
                        state_d = (shamt == 5'd1) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d = step1(data_q, op_q);
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign out_shifter = data_q;

endmodule

// File: tb/tb_sequential_shifter.sv
// Randomized scoreboard bench for sequential_shifter: driver pushes expected result and
// done cycle, monitor pops on each done pulse and also checks the busy window every cycle.
module tb_sequential_shifter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] inp_shifter = '0;
    logic [4:0]   shamt = '0;
    logic [1:0]   control = '0;
    logic         busy, done;
    logic [W-1:0] out_shifter;

    sequential_shifter #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .inp_shifter(inp_shifter),
        .shamt(shamt), .control(control), .busy(busy), .done(done),
        .out_shifter(out_shifter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] v;
        int           c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bstart = 1, bend = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int sh, input logic [1:0] c);
        logic [W-1:0] r;
        case (c)
            2'b00: r = a << sh;
            2'b01: r = a >> sh;
            2'b10: r = $signed(a) >>> sh;
            default: r = (sh == 0) ? a : ((a >> sh) | (a << (W - sh)));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic noise(input bit noisy);
        if (noisy) begin
            inp_shifter = $urandom;
            shamt       = 5'($urandom_range(0, 31));
            control     = 2'($urandom_range(0, 3));
            start       = 1'($urandom_range(0, 1));
        end else begin
            start = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic issue(input logic [W-1:0] a, input int sh, input logic [1:0] c, input bit noisy);
        int   l, e;
        exp_t x;
        l = (sh == 0) ? 1 : sh;
        inp_shifter = a;
        shamt       = 5'(sh);
        control     = c;
        start       = 1'b1;
        e      = cyc + 1;
        bstart = e;
        bend   = e + l - 1;
        x.v = ref_shift(a, sh, c);
        x.c = e + l - 1;
        q.push_back(x);
        repeat (l + 1) begin
            @(negedge clk);
            noise(noisy);
        end
        if (!noisy || $urandom_range(0, 3) == 0) start = 1'b0;
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", {31'b0, busy}, {31'b0, (cyc >= bstart && cyc <= bend)});
            if (q.size() > 0 && cyc > q[0].c) begin
                checks++; errors++;
                $display("FAIL missed_done: no done pulse, expected at cycle %0d, now %0d", q[0].c, cyc);
                void'(q.pop_front());
            end
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: done=1 with nothing outstanding at cycle %0d", cyc);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("result", out_shifter, x.v);
                    chk("latency", W'(cyc), W'(x.c));
                end
            end
        end
    end

    // watchdog
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int   e;
        logic [1:0] c;
        repeat (3) @(negedge clk);
        chk("rst_out",  out_shifter, '0);
        chk("rst_busy", {31'b0, busy}, '0);
        chk("rst_done", {31'b0, done}, '0);
        reset = 1'b0;
        @(negedge clk);

        issue(32'h0000_0001, 4, 2'b00, 1'b0);
        issue(32'h8000_0000, 31, 2'b10, 1'b0);
        issue(32'h0000_00F1, 4, 2'b11, 1'b0);
        issue(32'h0000_00F1, 4, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            c = 2'(i);
            issue(32'hDEAD_BEEF, 0, c, 1'b0);
        end
        issue(32'h8765_4321, 1, 2'b11, 1'b0);
        // held start: back-to-back with a single idle cycle
        issue(32'h1234_5678, 3, 2'b01, 1'b1);
        start = 1'b1;
        issue(32'hF000_000F, 2, 2'b10, 1'b1);

        // abort a shift with reset mid-operation
        inp_shifter = 32'hCAFE_F00D;
        shamt       = 5'd20;
        control     = 2'b01;
        start       = 1'b1;
        e      = cyc + 1;
        bstart = e;
        bend   = e + 19;
        repeat (10) begin
            @(negedge clk);
            noise(1'b1);
        end
        reset = 1'b1;
        bend  = cyc;
        @(negedge clk);
        chk("abort_out",  out_shifter, '0);
        chk("abort_busy", {31'b0, busy}, '0);
        chk("abort_done", {31'b0, done}, '0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        issue(32'h0000_0001, 4, 2'b00, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            logic [W-1:0] a;
            int sh;
            a  = $urandom;
            sh = (i % 16 == 0) ? 0 : $urandom_range(0, 31);
            c  = 2'($urandom_range(0, 3));
            issue(a, sh, c, 1'b1);
        end

        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_empty", W'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
